// File: rtl/des_pkg.sv
// DES key-schedule constants and permutation helpers.
// Bit numbering: DES bit 1 is the MSB of every vector handled here.
package des_pkg;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    // Permuted choice 1: 64-bit key -> 56 bits (C = first 28, D = last 28).
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: 56-bit C||D -> 48-bit round key.
    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount for rounds 1..16 (index = round - 1).
    localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[55 - i] = k[64 - PC1[i]];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[47 - i] = cd[56 - PC2[i]];
        end
        return o;
    endfunction

    // DES "left" moves bit 1 (the MSB) toward bit 28.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: emits K1..K16 (or K16..K1) one per handshake.
// C/D always hold the halves that produced the subkey currently presented,
// so the next subkey is one rotation plus PC-2 away.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dir_q, dir_d;
    logic [3:0]  count_q, count_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [3:0]  round_q, round_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [55:0] k56;
    logic [3:0]  sidx;
    logic        two;

    // Next-state: load on start, advance one round per handshake, finish after the 16th.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        dir_d    = dir_q;
        count_d  = count_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        round_d  = round_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        k56      = pc1(key_in);
        sidx     = dir_q ? (4'd15 - count_q) : (count_q + 4'd1);
        two      = (SHIFT[sidx] == 2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (decrypt) begin
                        // Total rotation over 16 rounds is 28, so C16/D16 = C0/D0.
                        c_d     = k56[55:28];
                        d_d     = k56[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl28(k56[55:28], 1'b0);
                        d_d     = rotl28(k56[27:0], 1'b0);
                        round_d = 4'd0;
                    end
                    subkey_d = pc2({c_d, d_d});
                    dir_d    = decrypt;
                    count_d  = 4'd0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (valid_q && subkey_ready) begin
                    if (count_q == 4'd15) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (dir_q) begin
                            // Undo the rotation of the round just emitted.
                            c_d     = rotr28(c_q, two);
                            d_d     = rotr28(d_q, two);
                            round_d = round_q - 4'd1;
                        end else begin
                            c_d     = rotl28(c_q, two);
                            d_d     = rotl28(d_q, two);
                            round_d = round_q + 4'd1;
                        end
                        subkey_d = pc2({c_d, d_d});
                        count_d  = count_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            dir_q    <= 1'b0;
            count_q  <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            round_q  <= round_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES key-schedule generator. It sits directly upstream of the round datapath's key-mix XOR, which feeds the S-box bank S1..S8. It latches a 64-bit key and emits the 16 48-bit round subkeys, one per accepted handshake. Order is K1..K16 for encryption and K16..K1 for decryption. It uses PC-1, per-round rotations and PC-2, and stores no subkey table.

Parameters:
- none. The DES tables are fixed constants in the package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new schedule; sampled only in IDLE
- key_in  in  64  DES key; key_in[63] = DES bit 1; parity bits (DES 8,16,...,64) ignored
- decrypt  in  1  sampled with start; 0 = K1..K16, 1 = K16..K1
- subkey  out  48  current round key; subkey[47] = PC-2 output bit 1
- subkey_valid  out  1  subkey/round_idx are valid
- subkey_ready  in  1  consumer accepts; a handshake occurs when valid && ready
- round_idx  out  4  DES round number minus 1 of the presented key (0..15)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values (rst sampled high at clk edge): state=IDLE, C=D=0, count=0, subkey=0, subkey_valid=0, round_idx=0, busy=0, done=0. Reset mid-run aborts with no done pulse.
- States: IDLE, RUN. All outputs are registered.
- IDLE with start=1 at edge t:
  - C,D <= PC-1(key_in), 28 bits each.
  - dir <= decrypt; count <= 0; busy <= 1; state <= RUN.
  - The first subkey is presented at edge t+1 (latency 1 cycle).
- Encrypt, first key: rotate C,D left by SHIFT(1) before applying PC-2, i.e. subkey = PC-2(rotl(C0,D0)).
- Decrypt, first key: K16 = PC-2(C0,D0), since the total rotation is 28 and returns to the initial value.
- RUN, on handshake with count<15: count++; present the next subkey on the following edge.
  - Encrypt: rotate left by SHIFT(r+1).
  - Decrypt: rotate right by SHIFT(r), where r is the round just emitted.
  - SHIFT = 1 for rounds 1, 2, 9, 16; 2 otherwise.
- RUN with valid && !ready: subkey, round_idx and C,D hold unchanged (stall, any length).
- RUN, handshake with count==15:
  - Next edge: subkey_valid=0, busy=0, done=1, state=IDLE.
  - done drops on the following edge.
- round_idx: 0..15 ascending for encrypt; 15..0 descending for decrypt.
- start while RUN: ignored. start in the same cycle done is high: accepted, since the state is already IDLE.
- key_in/decrypt changes after acceptance: no effect.
- The round datapath XORs subkey with E(R). Slice subkey[11:6] (DES bits 37..42) goes to S-box 7.
- Alternative encrypt implementation: keep the post-rotation C,D registered and compute PC-2 combinationally into the subkey register. This is acceptable provided the cycle timing above is met exactly.

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries), PC2 table (48 entries), SHIFT table (16 entries);
  - function pc1(64)->56, function pc2(56)->48;
  - rotl28/rotr28 by 1 or 2;
  - state enum {IDLE, RUN}.
- No sub-module. This is a single block; the permutations are package functions.

Test Plan:
- Encrypt, key_in=0x133457799BBCDFF1, ready held 1 -> 16 consecutive valid cycles starting the cycle after start.
  - round_idx 0: subkey=0x1B02EFFC7072.
  - round_idx 1: subkey=0x79AED9DBC9E5.
  - round_idx 15: subkey=0xCB3D8B0E17F5.
  - done pulses once, one cycle after the last handshake.
- Decrypt with the same key -> first subkey 0xCB3D8B0E17F5 with round_idx=15, last subkey 0x1B02EFFC7072 with round_idx=0. The full sequence is the exact reverse of the encrypt run.
- Backpressure: ready=0 for 5 cycles at round_idx 3 -> subkey/round_idx stable throughout. The sequence resumes identically, and total run length is 16+5 valid cycles.
- Reset at round_idx 7 -> next cycle all outputs are 0 and state is IDLE, with no done. A new start gives K1 with no stale state.
- start pulsed during RUN with a different key -> ignored, and the output still matches the original key.
- Back-to-back run: start asserted in the done cycle -> accepted, and the next K1 appears the following cycle.
- key_in=0 -> all 16 subkeys are 0.
- key_in=0x0101010101010101 (parity bits only) -> all subkeys 0.
